// File: rtl/mips_hazard_scoreboard.sv
// RAW-hazard scoreboard beside ID: one countdown per register until its in-flight write lands.
// Optional stall statistics (stall_cycles, raw_events) are built when MIPS_SB_STATS_EN is defined.
module mips_hazard_scoreboard #(
    parameter int unsigned NREG        = 32,
    parameter int unsigned AW          = 5,
    parameter int unsigned WB_LAT      = 3,
    parameter int unsigned FLUSH_DEPTH = 1
) (
    input  logic            clk1,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_wr,
    input  logic [AW-1:0]   id_rd,
    input  logic            flush,
    output logic            stall,
    output logic            issue,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     pending
`ifdef MIPS_SB_STATS_EN
    ,
    output logic [15:0]     stall_cycles,
    output logic [15:0]     raw_events
`endif
);

    localparam int unsigned CW = $clog2(WB_LAT + 1);
    localparam int unsigned PW = AW + 1;
    localparam logic [CW-1:0] Reload  = CW'(WB_LAT);
    // Counters above this value belong to the FLUSH_DEPTH youngest issues.
    localparam logic [CW-1:0] KillMin = CW'(WB_LAT - FLUSH_DEPTH);

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];
    logic [AW-1:0] rs_idx, rt_idx, rd_idx;
    logic          hz_rs, hz_rt;

    function automatic logic [AW-1:0] map_idx(input logic [AW-1:0] idx);
        return (32'(idx) < NREG) ? idx : '0;
    endfunction

    assign rs_idx = map_idx(id_rs);
    assign rt_idx = map_idx(id_rt);
    assign rd_idx = map_idx(id_rd);

    always_comb begin
        busy = '0;
        for (int n = 1; n < NREG; n++) begin
            busy[n] = (cnt_q[n] != '0);
        end
    end

    always_comb begin
        pending = '0;
        for (int n = 0; n < NREG; n++) begin
            pending = pending + PW'(busy[n]);
        end
    end

    assign hz_rs = id_use_rs & (rs_idx != '0) & busy[rs_idx];
    assign hz_rt = id_use_rt & (rt_idx != '0) & busy[rt_idx];
    assign stall = id_valid & (hz_rs | hz_rt) & ~flush;
    assign issue = rst_n & id_valid & ~stall & ~flush;

    always_comb begin
        for (int n = 0; n < NREG; n++) begin
            cnt_d[n] = cnt_q[n];
            if (n == 0) begin
                cnt_d[n] = '0;
            end else if (issue && id_wr && rd_idx == AW'(n)) begin
                cnt_d[n] = Reload;
            end else if (flush && cnt_q[n] > KillMin) begin
                cnt_d[n] = '0;
            end else if (cnt_q[n] != '0) begin
                cnt_d[n] = cnt_q[n] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NREG; n++) cnt_q[n] <= '0;
        end else begin
            for (int n = 0; n < NREG; n++) cnt_q[n] <= cnt_d[n];
        end
    end

`ifdef MIPS_SB_STATS_EN
    logic [15:0] stall_cycles_q, raw_events_q;
    logic        stall_prev_q;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            raw_events_q   <= '0;
            stall_prev_q   <= 1'b0;
        end else begin
            stall_prev_q <= stall;
            if (stall && stall_cycles_q != 16'hFFFF) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
            if (stall && !stall_prev_q && raw_events_q != 16'hFFFF) begin
                raw_events_q <= raw_events_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign raw_events   = raw_events_q;
`endif

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Self-checking bench for mips_hazard_scoreboard; reference model tracks per-register issue times.
`timescale 1ns/1ps
module tb_mips_hazard_scoreboard;
    localparam int NREG = 32, AW = 5, LAT = 3, FD = 1;
    localparam int NEVER = -1000000;

    logic            clk1 = 1'b0, rst_n = 1'b0;
    logic            id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr = 1'b0;
    logic            flush = 1'b0;
    logic [AW-1:0]   id_rs = '0, id_rt = '0, id_rd = '0;
    logic            stall, issue;
    logic [NREG-1:0] busy;
    logic [AW:0]     pending;

    int errors = 0, checks = 0, cyc = 0;
    int wr_time [NREG];

    always #5 clk1 = ~clk1;

`ifdef MIPS_SB_STATS_EN
    logic [15:0] stall_cycles, raw_events;
    logic            s_stall, s_issue;
    logic [NREG-1:0] s_busy;
    logic [AW:0]     s_pending;
    logic [15:0]     s_stall_cycles, s_raw_events;

    mips_hazard_scoreboard #(.NREG(NREG), .AW(AW), .WB_LAT(15), .FLUSH_DEPTH(FD)) dut_sat (
        .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_rd(id_rd),
        .flush(flush), .stall(s_stall), .issue(s_issue), .busy(s_busy), .pending(s_pending),
        .stall_cycles(s_stall_cycles), .raw_events(s_raw_events));
`endif

    mips_hazard_scoreboard #(.NREG(NREG), .AW(AW), .WB_LAT(LAT), .FLUSH_DEPTH(FD)) dut (
        .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_rd(id_rd),
        .flush(flush), .stall(stall), .issue(issue), .busy(busy), .pending(pending)
`ifdef MIPS_SB_STATS_EN
        , .stall_cycles(stall_cycles), .raw_events(raw_events)
`endif
    );

    // Reference model: a register is pending for LAT cycles after its latest surviving writer issued.
    function automatic int m_idx(input logic [AW-1:0] v);
        return (int'(v) < NREG) ? int'(v) : 0;
    endfunction

    function automatic bit m_busy(input int n);
        return n != 0 && wr_time[n] != NEVER && (cyc - wr_time[n]) <= LAT;
    endfunction

    function automatic bit m_stall();
        bit h;
        h = (id_use_rs && m_busy(m_idx(id_rs))) || (id_use_rt && m_busy(m_idx(id_rt)));
        return id_valid && h && !flush;
    endfunction

    function automatic bit m_issue();
        return rst_n && id_valid && !m_stall() && !flush;
    endfunction

    function automatic logic [NREG-1:0] m_busyvec();
        logic [NREG-1:0] b;
        for (int n = 0; n < NREG; n++) b[n] = m_busy(n);
        return b;
    endfunction

    function automatic int m_pending();
        int c = 0;
        for (int n = 0; n < NREG; n++) if (m_busy(n)) c++;
        return c;
    endfunction

    task automatic model_clear();
        for (int n = 0; n < NREG; n++) wr_time[n] = NEVER;
    endtask

    task automatic drive(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                         input bit wr, input int rd, input bit fl);
        @(negedge clk1);
        id_valid = v; id_rs = AW'(rs); id_use_rs = urs; id_rt = AW'(rt); id_use_rt = urt;
        id_wr = wr; id_rd = AW'(rd); flush = fl;
        #1;
    endtask

    // Advance one edge and update the model from the inputs presented at that edge.
    task automatic tick();
        bit iss;
        @(posedge clk1);
        iss = m_issue();
        if (iss && id_wr && m_idx(id_rd) != 0) begin
            wr_time[m_idx(id_rd)] = cyc;
        end else if (flush) begin
            for (int n = 1; n < NREG; n++)
                if (wr_time[n] != NEVER && (cyc - wr_time[n]) <= FD) wr_time[n] = NEVER;
        end
        if (!rst_n) model_clear();
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin drive(0, 0, 0, 0, 0, 0, 0, 0); tick(); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        drive(1, 1, 1, 2, 1, 1, 3, 0);
        checks++;
        if (stall !== 1'b0 || issue !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: stall=%b issue=%b expected 0 0", stall, issue);
        end
        checks++;
        if (busy !== '0 || pending !== '0) begin
            errors++;
            $display("FAIL reset_busy: busy=%h pending=%0d expected 0 0", busy, pending);
        end
        tick();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_independent();
        idle(1);
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 1, 0, 0, 1, i, 0);
            checks++;
            if (stall !== 1'b0 || issue !== 1'b1) begin
                errors++;
                $display("FAIL indep_issue%0d: stall=%b issue=%b expected 0 1", i, stall, issue);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (busy !== 32'h0000_000E || pending !== 6'd3) begin
            errors++;
            $display("FAIL indep_busy: busy=%h pending=%0d expected 0000000e 3", busy, pending);
        end
        tick();
    endtask

    task automatic test_raw();
        idle(4);
        drive(1, 0, 1, 0, 0, 1, 1, 0);
        tick();
        for (int k = 1; k <= 3; k++) begin
            drive(1, 1, 1, 2, 1, 1, 4, 0);
            checks++;
            if (stall !== 1'b1 || issue !== 1'b0) begin
                errors++;
                $display("FAIL raw_stall_c%0d: stall=%b issue=%b expected 1 0", k, stall, issue);
            end
            tick();
        end
        drive(1, 1, 1, 2, 1, 1, 4, 0);
        checks++;
        if (stall !== 1'b0 || issue !== 1'b1 || busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL raw_release: stall=%b issue=%b busy1=%b expected 0 1 0",
                     stall, issue, busy[1]);
        end
        tick();
    endtask

    task automatic test_waw();
        idle(4);
        drive(1, 0, 1, 0, 0, 1, 5, 0); tick();
        drive(1, 0, 1, 0, 0, 1, 5, 0); tick();
        for (int k = 2; k <= 5; k++) begin
            drive(1, 5, 1, 0, 0, 0, 0, 0);
            checks++;
            if (stall !== (k <= 4)) begin
                errors++;
                $display("FAIL waw_c%0d: stall=%b expected %b", k, stall, k <= 4);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        idle(4);
        drive(1, 0, 1, 0, 0, 1, 8, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 0, 0, 1, 7, 0); tick();
        drive(1, 7, 1, 0, 0, 1, 9, 1);
        checks++;
        if (stall !== 1'b0 || issue !== 1'b0) begin
            errors++;
            $display("FAIL flush_ctl: stall=%b issue=%b expected 0 0", stall, issue);
        end
        checks++;
        if (busy !== 32'h0000_0180) begin
            errors++;
            $display("FAIL flush_pre: busy=%h expected 00000180", busy);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (busy !== '0 || pending !== '0) begin
            errors++;
            $display("FAIL flush_post: busy=%h pending=%0d expected 0 0", busy, pending);
        end
        tick();
    endtask

    task automatic test_r0();
        idle(4);
        drive(1, 0, 1, 0, 0, 1, 0, 0); tick();
        drive(1, 0, 1, 0, 1, 0, 0, 0);
        checks++;
        if (stall !== 1'b0 || issue !== 1'b1 || busy !== '0) begin
            errors++;
            $display("FAIL r0: stall=%b issue=%b busy=%h expected 0 1 0", stall, issue, busy);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        idle(4);
        drive(1, 0, 1, 0, 0, 1, 3, 0); tick();
        drive(1, 3, 1, 0, 0, 0, 0, 0); tick();
        drive(1, 3, 1, 0, 0, 0, 0, 0);
        checks++;
        if (stall !== 1'b1 || busy[3] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: stall=%b busy3=%b expected 1 1", stall, busy[3]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== '0 || stall !== 1'b0 || pending !== '0) begin
            errors++;
            $display("FAIL rstmid_async: busy=%h stall=%b pending=%0d expected 0 0 0",
                     busy, stall, pending);
        end
        model_clear();
        tick();
        #2 rst_n = 1'b1;
        drive(1, 3, 1, 0, 0, 0, 0, 0);
        checks++;
        if (stall !== 1'b0 || issue !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after: stall=%b issue=%b expected 0 1", stall, issue);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 9) == 0);
            checks++;
            if (stall !== m_stall()) begin
                errors++;
                $display("FAIL rnd_stall@%0d: got %b expected %b", i, stall, m_stall());
            end
            checks++;
            if (issue !== m_issue()) begin
                errors++;
                $display("FAIL rnd_issue@%0d: got %b expected %b", i, issue, m_issue());
            end
            checks++;
            if (busy !== m_busyvec()) begin
                errors++;
                $display("FAIL rnd_busy@%0d: got %h expected %h", i, busy, m_busyvec());
            end
            checks++;
            if (int'(pending) != m_pending()) begin
                errors++;
                $display("FAIL rnd_pending@%0d: got %0d expected %0d", i, pending, m_pending());
            end
            tick();
        end
    endtask

`ifdef MIPS_SB_STATS_EN
    task automatic test_stats();
        idle(1);
        rst_n = 1'b0; #2 rst_n = 1'b1;
        model_clear();
        for (int r = 0; r < 2; r++) begin
            idle(4);
            drive(1, 0, 1, 0, 0, 1, 1, 0); tick();
            repeat (4) begin drive(1, 1, 1, 0, 0, 0, 0, 0); tick(); end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (stall_cycles !== 16'd6 || raw_events !== 16'd2) begin
            errors++;
            $display("FAIL stats_two_raw: stall_cycles=%0d raw_events=%0d expected 6 2",
                     stall_cycles, raw_events);
        end
        rst_n = 1'b0; #2 rst_n = 1'b1;
        model_clear();
        for (int r = 0; r < 4667; r++) begin
            @(negedge clk1);
            id_valid = 1'b1; id_use_rs = 1'b1; id_rs = '0; id_wr = 1'b1; id_rd = AW'(1);
            @(negedge clk1);
            id_rs = AW'(1); id_wr = 1'b0;
            repeat (14) @(negedge clk1);
        end
        #1;
        checks++;
        if (s_stall_cycles !== 16'hFFFF || s_raw_events !== 16'd4667) begin
            errors++;
            $display("FAIL stats_sat: stall_cycles=%h raw_events=%0d expected ffff 4667",
                     s_stall_cycles, s_raw_events);
        end
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_independent();
        test_raw();
        test_waw();
        test_flush();
        test_r0();
        test_reset_mid();
        test_random();
`ifdef MIPS_SB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
